// File: rtl/cbfp_pkg.sv
// Shared types and helpers for the block-floating-point normaliser.
package cbfp_pkg;

  localparam int unsigned LSC_W = 8;

  // Leading-sign counts; wide enough for any supported sample width.
  typedef logic [LSC_W-1:0] exp_t;

  function automatic int unsigned exp_w(input int unsigned max_shift);
    return (max_shift == 0) ? 1 : int'($clog2(max_shift + 1));
  endfunction

  function automatic logic signed [32:0] round_half_up(input logic signed [31:0] top,
                                                        input logic              rbit);
    return 33'(top) + 33'(rbit);
  endfunction

  // Only positive overflow can occur after a half-up increment.
  function automatic logic [31:0] saturate(input logic signed [32:0] v, input int unsigned ow);
    logic signed [32:0] mx;
    mx = (33'sd1 <<< (ow - 1)) - 33'sd1;
    return (v > mx) ? mx[31:0] : v[31:0];
  endfunction

endpackage

// File: rtl/cbfp_norm_stage_if.sv
// Beat bus between a butterfly stage and the normaliser (inputs, outputs, framing).
interface cbfp_norm_stage_if
  import cbfp_pkg::*;
#(
  parameter int unsigned I_WIDTH   = 24,
  parameter int unsigned O_WIDTH   = 12,
  parameter int unsigned LANES     = 16,
  parameter int unsigned MAX_SHIFT = 12
);
  localparam int unsigned EXP_W = exp_w(MAX_SHIFT);

  logic                              i_valid;
  logic                              i_sof;
  logic [LANES-1:0][I_WIDTH-1:0]     din_re;
  logic [LANES-1:0][I_WIDTH-1:0]     din_im;
  logic                              o_valid;
  logic                              o_sof;
  logic                              o_eof;
  logic [LANES-1:0][O_WIDTH-1:0]     dout_re;
  logic [LANES-1:0][O_WIDTH-1:0]     dout_im;
  logic [LANES-1:0][EXP_W-1:0]       o_exp;
  logic                              o_align_err;

  modport master (output i_valid, i_sof, din_re, din_im,
                  input  o_valid, o_sof, o_eof, dout_re, dout_im, o_exp, o_align_err);
  modport slave  (input  i_valid, i_sof, din_re, din_im,
                  output o_valid, o_sof, o_eof, dout_re, dout_im, o_exp, o_align_err);
endinterface

// File: rtl/cbfp_lsc.sv
// Combinational leading-sign counter: bits below the MSB equal to the sign bit.
module cbfp_lsc
  import cbfp_pkg::*;
#(
  parameter int unsigned W = 24
) (
  input  logic [W-1:0] x,
  output exp_t         lsc_c
);

  logic run;

  always_comb begin
    lsc_c = '0;
    run   = 1'b1;
    for (int i = int'(W) - 2; i >= 0; i--) begin
      if (run && (x[i] == x[W-1])) lsc_c = lsc_c + exp_t'(1);
      else                         run   = 1'b0;
    end
  end

endmodule

// File: rtl/cbfp_norm_stage.sv
// Block-floating-point normaliser: lsc -> group minimum -> shift/narrow, 3-cycle latency.
// Define CBFP_ROUND_EN for half-up rounding with positive saturation instead of truncation.
module cbfp_norm_stage
  import cbfp_pkg::*;
#(
  parameter int unsigned I_WIDTH     = 24,
  parameter int unsigned O_WIDTH     = 12,
  parameter int unsigned LANES       = 16,
  parameter int unsigned GROUP       = 8,
  parameter int unsigned MAX_SHIFT   = 12,
  parameter int unsigned BLOCK_BEATS = 32
) (
  input logic              clk,
  input logic              rst,
  cbfp_norm_stage_if.slave bus
);

  localparam int unsigned EXP_W = exp_w(MAX_SHIFT);
  localparam int unsigned NGRP  = LANES / GROUP;
  localparam int unsigned CNT_W = (BLOCK_BEATS > 1) ? $clog2(BLOCK_BEATS) : 1;
  localparam int unsigned DROP  = I_WIDTH - O_WIDTH;

  typedef logic [I_WIDTH-1:0] samp_t;
  typedef logic [EXP_W-1:0]   shift_t;

  exp_t lre_c [LANES];
  exp_t lim_c [LANES];

  for (genvar l = 0; l < int'(LANES); l++) begin : g_lsc
    cbfp_lsc #(.W(I_WIDTH)) u_re (.x(bus.din_re[l]), .lsc_c(lre_c[l]));
    cbfp_lsc #(.W(I_WIDTH)) u_im (.x(bus.din_im[l]), .lsc_c(lim_c[l]));
  end

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cur_c;
  logic             v1, sof1, eof1;
  samp_t            re1 [LANES];
  samp_t            im1 [LANES];
  exp_t             lre1 [LANES];
  exp_t             lim1 [LANES];

  assign cur_c = bus.i_sof ? '0 : cnt_q;

  // S1: capture samples, their lsc, and the framing position of the beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1              <= 1'b0;
      sof1            <= 1'b0;
      eof1            <= 1'b0;
      cnt_q           <= '0;
      bus.o_align_err <= 1'b0;
      for (int l = 0; l < int'(LANES); l++) begin
        re1[l]  <= '0;
        im1[l]  <= '0;
        lre1[l] <= '0;
        lim1[l] <= '0;
      end
    end else begin
      v1 <= bus.i_valid;
      if (bus.i_valid) begin
        sof1  <= (cur_c == '0);
        eof1  <= (cur_c == CNT_W'(BLOCK_BEATS - 1));
        cnt_q <= (cur_c == CNT_W'(BLOCK_BEATS - 1)) ? '0 : cur_c + CNT_W'(1);
        if (bus.i_sof && (cnt_q != '0)) bus.o_align_err <= 1'b1;
        for (int l = 0; l < int'(LANES); l++) begin
          re1[l]  <= bus.din_re[l];
          im1[l]  <= bus.din_im[l];
          lre1[l] <= lre_c[l];
          lim1[l] <= lim_c[l];
        end
      end
    end
  end

  exp_t grp_min_c [NGRP];

  always_comb begin
    for (int g = 0; g < int'(NGRP); g++) begin
      grp_min_c[g] = exp_t'(MAX_SHIFT);
      for (int l = 0; l < int'(GROUP); l++) begin
        if (lre1[g*GROUP+l] < grp_min_c[g]) grp_min_c[g] = lre1[g*GROUP+l];
        if (lim1[g*GROUP+l] < grp_min_c[g]) grp_min_c[g] = lim1[g*GROUP+l];
      end
    end
  end

  logic   v2, sof2, eof2;
  samp_t  re2 [LANES];
  samp_t  im2 [LANES];
  shift_t m2  [NGRP];

  // S2: register the capped group minimum alongside the data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2   <= 1'b0;
      sof2 <= 1'b0;
      eof2 <= 1'b0;
      for (int l = 0; l < int'(LANES); l++) begin
        re2[l] <= '0;
        im2[l] <= '0;
      end
      for (int g = 0; g < int'(NGRP); g++) m2[g] <= '0;
    end else begin
      v2 <= v1;
      if (v1) begin
        sof2 <= sof1;
        eof2 <= eof1;
        for (int l = 0; l < int'(LANES); l++) begin
          re2[l] <= re1[l];
          im2[l] <= im1[l];
        end
        for (int g = 0; g < int'(NGRP); g++) m2[g] <= EXP_W'(grp_min_c[g]);
      end
    end
  end

  // Shift within I_WIDTH, then keep the top O_WIDTH bits (plus one guard bit when rounding).
  function automatic logic [O_WIDTH-1:0] narrow(input samp_t x, input shift_t m);
`ifdef CBFP_ROUND_EN
    logic [O_WIDTH:0] ext;
    ext = (O_WIDTH+1)'({x << m, 1'b0} >> DROP);
    return O_WIDTH'(saturate(round_half_up(32'(signed'(ext[O_WIDTH:1])), ext[0]), O_WIDTH));
`else
    return O_WIDTH'((x << m) >> DROP);
`endif
  endfunction

  logic [O_WIDTH-1:0] dre_c [LANES];
  logic [O_WIDTH-1:0] dim_c [LANES];

  always_comb begin
    for (int l = 0; l < int'(LANES); l++) begin
      dre_c[l] = narrow(re2[l], m2[l/GROUP]);
      dim_c[l] = narrow(im2[l], m2[l/GROUP]);
    end
  end

  // S3: output registers; framing flags are qualified by valid, data is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.o_valid <= 1'b0;
      bus.o_sof   <= 1'b0;
      bus.o_eof   <= 1'b0;
      bus.dout_re <= '0;
      bus.dout_im <= '0;
      bus.o_exp   <= '0;
    end else begin
      bus.o_valid <= v2;
      bus.o_sof   <= v2 & sof2;
      bus.o_eof   <= v2 & eof2;
      if (v2) begin
        for (int l = 0; l < int'(LANES); l++) begin
          bus.dout_re[l] <= dre_c[l];
          bus.dout_im[l] <= dim_c[l];
          bus.o_exp[l]   <= m2[l/GROUP];
        end
      end
    end
  end

endmodule

// File: tb/tb_cbfp_norm_stage.sv
// Randomised + directed bench for cbfp_norm_stage against an arithmetic reference model.
module tb_cbfp_norm_stage;
  import cbfp_pkg::*;

  localparam int unsigned IW = 24, OW = 12, LN = 16, GP = 8, MS = 12, BB = 32;
  localparam int unsigned EW = exp_w(MS);

  typedef logic [LN-1:0][IW-1:0] vin_t;
  typedef struct {
    int                 due;
    logic               sof;
    logic               eof;
    logic [LN*OW-1:0]   re;
    logic [LN*OW-1:0]   im;
    logic [LN*EW-1:0]   ex;
  } exp_beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cbfp_norm_stage_if #(.I_WIDTH(IW), .O_WIDTH(OW), .LANES(LN), .MAX_SHIFT(MS)) bus ();

  cbfp_norm_stage #(
    .I_WIDTH(IW), .O_WIDTH(OW), .LANES(LN), .GROUP(GP), .MAX_SHIFT(MS), .BLOCK_BEATS(BB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int        total = 0, bad = 0, cyc = 0;
  int        blk_idx = 0;
  logic      err_m = 1'b0;
  int        n_ov = 0, n_sof = 0, n_eof = 0;
  exp_beat_t q[$];

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Largest shift that keeps x*2^m inside the signed IW-bit range.
  function automatic int lsc_of(input logic [IW-1:0] x);
    longint sx, lo, hi;
    int     m;
    sx = longint'($signed(x));
    lo = -(64'sd1 <<< (IW - 1));
    hi = (64'sd1 <<< (IW - 1)) - 1;
    m  = 0;
    while (m < int'(IW) - 1 && sx * (64'sd1 <<< (m + 1)) >= lo && sx * (64'sd1 <<< (m + 1)) <= hi)
      m++;
    return m;
  endfunction

  function automatic logic [OW-1:0] out_of(input logic [IW-1:0] x, input int m);
    longint y, t;
    y = longint'($signed(x)) * (64'sd1 <<< m);
`ifdef CBFP_ROUND_EN
    t = (y + (64'sd1 <<< (IW - OW - 1))) >>> (IW - OW);
    if (t > (64'sd1 <<< (OW - 1)) - 1) t = (64'sd1 <<< (OW - 1)) - 1;
`else
    t = y >>> (IW - OW);
`endif
    return OW'(t);
  endfunction

  task automatic push_model(input logic s, input vin_t re, input vin_t im);
    exp_beat_t e;
    int        idx;
    int        m [LN/GP];
    idx = s ? 0 : blk_idx;
    if (s && blk_idx != 0) err_m = 1'b1;
    e.sof   = (idx == 0);
    e.eof   = (idx == int'(BB) - 1);
    blk_idx = (idx + 1) % int'(BB);
    for (int g = 0; g < int'(LN/GP); g++) begin
      m[g] = MS;
      for (int l = g*GP; l < (g+1)*GP; l++) begin
        if (lsc_of(re[l]) < m[g]) m[g] = lsc_of(re[l]);
        if (lsc_of(im[l]) < m[g]) m[g] = lsc_of(im[l]);
      end
    end
    for (int l = 0; l < int'(LN); l++) begin
      e.re[l*OW +: OW] = out_of(re[l], m[l/GP]);
      e.im[l*OW +: OW] = out_of(im[l], m[l/GP]);
      e.ex[l*EW +: EW] = EW'(m[l/GP]);
    end
    e.due = cyc + 3;
    q.push_back(e);
  endtask

  function automatic logic [IW-1:0] rnd24();
    logic signed [IW-1:0] v;
    v = IW'($urandom);
    v = v >>> $urandom_range(0, IW - 1);
    return v;
  endfunction

  function automatic vin_t rnd_vec();
    vin_t v;
    for (int l = 0; l < int'(LN); l++) v[l] = rnd24();
    return v;
  endfunction

  task automatic drive(input logic v, input logic s, input vin_t re, input vin_t im);
    @(negedge clk);
    bus.i_valid = v;
    bus.i_sof   = s;
    bus.din_re  = re;
    bus.din_im  = im;
    if (v) push_model(s, re, im);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, rnd_vec(), rnd_vec());
  endtask

  // One beat followed by a bubble; returns just after its output is registered.
  task automatic beat_and_look(input logic s, input vin_t re, input vin_t im);
    drive(1'b1, s, re, im);
    drive(1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst         = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_sof   = 1'b0;
    q.delete();
    blk_idx = 0;
    err_m   = 1'b0;
    #1;
    check("rst_valid", bus.o_valid, 1'b0);
    check("rst_sof", bus.o_sof, 1'b0);
    check("rst_eof", bus.o_eof, 1'b0);
    check("rst_dout_re", bus.dout_re, '0);
    check("rst_exp", bus.o_exp, '0);
    check("rst_err", bus.o_align_err, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Scoreboard: every cycle either the due beat appears with the model's fields, or nothing does.
  always @(posedge clk) begin
    exp_beat_t e;
    cyc++;
    #1;
    if (!rst) begin
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        check("valid", bus.o_valid, 1'b1);
        check("sof", bus.o_sof, e.sof);
        check("eof", bus.o_eof, e.eof);
        check("dout_re", bus.dout_re, e.re);
        check("dout_im", bus.dout_im, e.im);
        check("exp", bus.o_exp, e.ex);
      end else begin
        check("idle_valid", bus.o_valid, 1'b0);
      end
      check("align_err", bus.o_align_err, err_m);
      if (bus.o_valid) begin
        n_ov++;
        if (bus.o_sof) n_sof++;
        if (bus.o_eof) n_eof++;
      end
    end
  end

  initial begin
    vin_t a, b;
    int   ov0, sof0, eof0;
    bus.i_valid = 1'b0;
    bus.i_sof   = 1'b0;
    bus.din_re  = '0;
    bus.din_im  = '0;
    do_reset();

    // Small uniform input: shift capped at MAX_SHIFT.
    for (int l = 0; l < int'(LN); l++) begin a[l] = 24'h000100; b[l] = 24'h000100; end
    beat_and_look(1'b1, a, b);
    check("t1_re0", bus.dout_re[0], 12'h100);
    check("t1_im15", bus.dout_im[15], 12'h100);
    check("t1_exp0", bus.o_exp[0], 4'd12);
    check("t1_sof", bus.o_sof, 1'b1);

    // One full-scale lane pins group 0 at shift 0; group 1 unaffected.
    a[3] = 24'h7FFFFF;
    beat_and_look(1'b0, a, b);
    check("t2_exp_g0", bus.o_exp[0], 4'd0);
    check("t2_re3", bus.dout_re[3], 12'h7FF);
    check("t2_re1", bus.dout_re[1], 12'h000);
    check("t2_exp_g1", bus.o_exp[8], 4'd12);
    check("t2_re8", bus.dout_re[8], 12'h100);

    // Rounding boundary and saturation at shift 0.
    a[0] = 24'h7FFFFF; a[1] = 24'h000800; a[2] = 24'h7FF800; a[3] = 24'h000100;
    beat_and_look(1'b0, a, b);
`ifdef CBFP_ROUND_EN
    check("t3_re1", bus.dout_re[1], 12'h001);
`else
    check("t3_re1", bus.dout_re[1], 12'h000);
`endif
    check("t3_re2", bus.dout_re[2], 12'h7FF);
    check("t3_re0", bus.dout_re[0], 12'h7FF);

    // Only 0 and -1: maximum shift, values preserved.
    for (int l = 0; l < int'(LN); l++) begin
      a[l] = (l % 2 == 1) ? '1 : '0;
      b[l] = (l % 2 == 1) ? '0 : '1;
    end
    beat_and_look(1'b0, a, b);
    check("t4_exp0", bus.o_exp[0], 4'd12);
    check("t4_exp8", bus.o_exp[8], 4'd12);
    check("t4_re1", bus.dout_re[1], 12'hFFF);
    check("t4_re0", bus.dout_re[0], 12'h000);
    check("t4_im0", bus.dout_im[0], 12'hFFF);

    // Full block with a gap, then a misaligned sof in the following block.
    do_reset();
    ov0 = n_ov; sof0 = n_sof; eof0 = n_eof;
    for (int k = 0; k < int'(BB); k++) begin
      drive(1'b1, k == 0, rnd_vec(), rnd_vec());
      if (k == 10) idle(3);
    end
    idle(4);
    check("t5_nvalid", 32'(n_ov - ov0), 32'd32);
    check("t5_nsof", 32'(n_sof - sof0), 32'd1);
    check("t5_neof", 32'(n_eof - eof0), 32'd1);
    check("t5_err0", bus.o_align_err, 1'b0);
    sof0 = n_sof;
    for (int k = 0; k < 6; k++) drive(1'b1, k == 5, rnd_vec(), rnd_vec());
    idle(4);
    check("t5_err1", bus.o_align_err, 1'b1);
    check("t5_nsof2", 32'(n_sof - sof0), 32'd2);

    // Reset with beats in flight; first beat afterwards starts a block.
    for (int k = 0; k < 17; k++) drive(1'b1, 1'b0, rnd_vec(), rnd_vec());
    do_reset();
    idle(5);
    beat_and_look(1'b0, rnd_vec(), rnd_vec());
    check("t6_valid", bus.o_valid, 1'b1);
    check("t6_sof", bus.o_sof, 1'b1);

    // Random traffic with bubbles and occasional sof.
    for (int k = 0; k < 600; k++) begin
      logic v;
      v = ($urandom_range(0, 9) < 7);
      drive(v, v && ($urandom_range(0, 31) == 0), rnd_vec(), rnd_vec());
    end
    idle(6);
    check("drain_empty", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
